// File: rtl/bitwise_if.sv
// Operand/result handshake bundle for bitwise_pipe.
// Flag signals zr/ng exist only when BITWISE_FLAGS_EN is defined.
interface bitwise_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
`ifdef BITWISE_FLAGS_EN
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out
    );
`endif
endinterface

// File: rtl/bitwise_pipe.sv
// WIDTH-bit bitwise logic unit feeding a DEPTH-entry output FIFO with a delivered-result counter.
// Optional macro BITWISE_FLAGS_EN adds per-entry zero (zr) and negative (ng) flags.
module bitwise_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bitwise_if.slave         bus,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [WIDTH-1:0] last_data;
    logic [WIDTH-1:0] result;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    always_comb begin
        result = '0;
        unique case (bus.op)
            3'b000: result = ~bus.a;
            3'b001: result = bus.a & bus.b;
            3'b010: result = bus.a | bus.b;
            3'b011: result = bus.a ^ bus.b;
            3'b100: result = ~(bus.a & bus.b);
            3'b101: result = ~(bus.a | bus.b);
            3'b110: result = ~(bus.a ^ bus.b);
            3'b111: result = bus.a;
            default: result = '0;
        endcase
    end

    // in_ready depends on registered count only, so a full FIFO refuses a push even during a pop
    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // last_data holds the most recently delivered result so out is stable while empty
    assign bus.out = bus.out_valid ? mem_data[rd_ptr] : last_data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            done_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_data <= mem_data[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                done_cnt  <= done_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef BITWISE_FLAGS_EN
    logic mem_zr [DEPTH];
    logic mem_ng [DEPTH];
    logic last_zr;
    logic last_ng;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_zr[wr_ptr] <= (result == '0);
            mem_ng[wr_ptr] <= result[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_zr <= 1'b1;
            last_ng <= 1'b0;
        end else if (pop) begin
            last_zr <= mem_zr[rd_ptr];
            last_ng <= mem_ng[rd_ptr];
        end
    end

    assign bus.zr = bus.out_valid ? mem_zr[rd_ptr] : last_zr;
    assign bus.ng = bus.out_valid ? mem_ng[rd_ptr] : last_ng;
`endif
endmodule

// File: tb/tb_bitwise_pipe.sv
// Self-checking bench for bitwise_pipe: truth-table reference model plus directed vectors.
module tb_bitwise_pipe;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] done_cnt;

    bitwise_if #(.WIDTH(WIDTH)) bus ();

    bitwise_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // per-op truth table, bit index {a_bit, b_bit}
    logic [3:0] tt [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                           4'b0111, 4'b0001, 4'b1001, 4'b1100};

    logic [15:0] mq[$];
    logic [15:0] mlast = 16'h0000;
    logic [15:0] mcnt  = 16'h0000;

    logic [15:0] sweep_exp [8] = '{16'h3C5A, 16'h03A0, 16'hCFF5, 16'hCC55,
                                   16'hFC5F, 16'h300A, 16'h33AA, 16'hC3A5};

    function automatic logic [15:0] model_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [3:0]  t;
        logic [15:0] r;
        t = tt[o];
        for (int i = 0; i < 16; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // reference model: FIFO as a queue, acceptance decided from model occupancy
    always @(posedge clk) begin
        bit mpush, mpop;
        if (!rst_n) begin
            mq.delete();
            mlast = 16'h0000;
            mcnt  = 16'h0000;
        end else begin
            mpush = bus.in_valid && (mq.size() != DEPTH);
            mpop  = bus.out_ready && (mq.size() != 0);
            if (mpop) begin
                mlast = mq.pop_front();
                mcnt  = mcnt + 16'd1;
            end
            if (mpush) mq.push_back(model_op(bus.op, bus.a, bus.b));
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp_out;
        if (chk_en) begin
            exp_out = (mq.size() != 0) ? mq[0] : mlast;
            check("m_in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
            check("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            check("m_out", 32'(bus.out), 32'(exp_out));
            check("m_done_cnt", 32'(done_cnt), 32'(mcnt));
`ifdef BITWISE_FLAGS_EN
            check("m_zr", 32'(bus.zr), 32'(exp_out == 16'h0000));
            check("m_ng", 32'(bus.ng), 32'(exp_out[15]));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        bus.in_valid = v;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;

        // reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'h0000);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
`ifdef BITWISE_FLAGS_EN
        check("rst_zr", 32'(bus.zr), 32'd1);
        check("rst_ng", 32'(bus.ng), 32'd0);
`endif
        step();

        // back-to-back NOT then XOR with consumer always ready
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b000, 16'h00FF, 16'h0000);
        step();
        check("t2_out0", 32'(bus.out), 32'hFF00);
        check("t2_valid0", 32'(bus.out_valid), 32'd1);
`ifdef BITWISE_FLAGS_EN
        check("t2_ng0", 32'(bus.ng), 32'd1);
`endif
        drive(1'b1, 3'b011, 16'hAAAA, 16'h0F0F);
        step();
        check("t2_out1", 32'(bus.out), 32'hA5A5);
`ifdef BITWISE_FLAGS_EN
        check("t2_ng1", 32'(bus.ng), 32'd1);
`endif
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();
        check("t2_empty", 32'(bus.out_valid), 32'd0);
        check("t2_done", 32'(done_cnt), 32'd2);
        check("t2_hold", 32'(bus.out), 32'hA5A5);

        // all eight ops on one operand pair
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), 16'hC3A5, 16'h0FF0);
            step();
            check($sformatf("sweep_op%0d", k), 32'(bus.out), 32'(sweep_exp[k]));
        end
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();
        check("sweep_done", 32'(done_cnt), 32'd10);

        // fill with consumer stalled, third push refused
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'hFFFF, 16'hFFFF);
        step();
        drive(1'b1, 3'b101, 16'h0000, 16'h0000);
        step();
        check("t3_full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 3'b111, 16'h1234, 16'h0000);
        step();
        check("t3_refused", 32'(bus.in_ready), 32'd0);
        check("t3_head0", 32'(bus.out), 32'h0000);
`ifdef BITWISE_FLAGS_EN
        check("t3_zr0", 32'(bus.zr), 32'd1);
`endif
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        bus.out_ready = 1'b1;
        step();
        check("t3_head1", 32'(bus.out), 32'hFFFF);
        step();
        check("t3_drained", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 3'b111, 16'h1234, 16'h5678);
        step();
        check("t3_repush", 32'(bus.out), 32'h1234);
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();
        check("t3_done", 32'(done_cnt), 32'd13);

        // steady state at count=1 with simultaneous push/pop, pointers wrap
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 16'h1000, 16'h0000);
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            drive(1'b1, 3'b111, 16'h1001 + 16'(i), 16'h0000);
            step();
            check("t4_valid", 32'(bus.out_valid), 32'd1);
            check("t4_ready", 32'(bus.in_ready), 32'd1);
            check("t4_order", 32'(bus.out), 32'h1001 + 32'(i));
        end
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();

        // reset while full, with push and pop requested in the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 16'hDEAD, 16'h0000);
        step();
        drive(1'b1, 3'b111, 16'hBEEF, 16'h0000);
        step();
        check("t5_full", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b111, 16'h5555, 16'h0000);
        step();
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_ready", 32'(bus.in_ready), 32'd1);
        check("t5_done", 32'(done_cnt), 32'd0);
        check("t5_out", 32'(bus.out), 32'h0000);
        repeat (3) step();
        check("t5_idle", 32'(bus.out_valid), 32'd0);

        // counter wrap after 65536 deliveries
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 16'h0000, 16'h0000);
        step();
        bus.out_ready = 1'b1;
        for (int i = 1; i < 65536; i++) begin
            drive(1'b1, 3'b111, 16'(i), 16'h0000);
            step();
        end
        check("t6_max", 32'(done_cnt), 32'h0000FFFF);
        drive(1'b0, 3'b000, 16'h0000, 16'h0000);
        step();
        check("t6_wrap", 32'(done_cnt), 32'd0);
        check("t6_last", 32'(bus.out), 32'h0000FFFF);
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
